// File: rtl/fu_arith_pkg.sv
// Shared definitions for the pipelined A64 integer add/sub functional unit.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package fu_arith_pkg;

    // Primary opcode byte inst[31:24]
    localparam logic [7:0] OPC_ADD_IMM  = 8'b10010001;
    localparam logic [7:0] OPC_ADDS_IMM = 8'b10110001;
    localparam logic [7:0] OPC_SUB_IMM  = 8'b11010001;
    localparam logic [7:0] OPC_SUBS_IMM = 8'b11110001;
    localparam logic [7:0] OPC_ADD_REG  = 8'b10001011;
    localparam logic [7:0] OPC_ADDS_REG = 8'b10101011;
    localparam logic [7:0] OPC_SUB_REG  = 8'b11001011;
    localparam logic [7:0] OPC_SUBS_REG = 8'b11101011;

    typedef enum logic [2:0] {ADD, ADDS, SUB, SUBS, INVALID} arith_op_e;

    // Bit positions of the flags inside result word [2]
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic arith_op_e decode_op(input logic [7:0] opc);
        case (opc)
            OPC_ADD_IMM,  OPC_ADD_REG:  decode_op = ADD;
            OPC_ADDS_IMM, OPC_ADDS_REG: decode_op = ADDS;
            OPC_SUB_IMM,  OPC_SUB_REG:  decode_op = SUB;
            OPC_SUBS_IMM, OPC_SUBS_REG: decode_op = SUBS;
            default:                    decode_op = INVALID;
        endcase
    endfunction

endpackage

// File: rtl/fu_arith_stage.sv
// One pipeline slot: payload register plus valid bit with load/hold/clear.
// Latency: 1 cycle from d_* to q_* when load_en is high.
// Backpressure: holds contents while load_en is low; clr/rst empty the slot.
// Ports: clk, rst (sync, active high), clr (flush), load_en, d_vld/d_dat in,
//        q_vld/q_dat out.
module fu_arith_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load_en,
    input  logic         d_vld,
    input  logic [W-1:0] d_dat,
    output logic         q_vld,
    output logic [W-1:0] q_dat
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q_vld <= 1'b0;
        end else if (load_en) begin
            q_vld <= d_vld;
        end
    end

    // Payload only changes when something real arrives; bubbles leave it untouched.
    always_ff @(posedge clk) begin
        if (load_en && d_vld) begin
            q_dat <= d_dat;
        end
    end

endmodule

// File: rtl/fu_arith_pipe.sv
// Pipelined A64 64-bit ADD/ADDS/SUB/SUBS (CMP/CMN), imm and reg forms.
// Latency: STAGES cycles issue-to-output; compute in stage 0, rest are delay slots.
// Backpressure: valid/ready toward writeback; bubbles collapse, full pipe holds.
// Ports: clk, rst (sync active-high), flush; issue side inst_valid/fu_ready/inst/
//        inst_id/op/out_prn/out_prn_valid; result side fu_out_valid/fu_out_ready/
//        fu_out_inst_id/fu_out_prn/fu_out_prn_valid/fu_out_data/fu_out_data_valid.
// Build option: define FU_ARITH_SHIFT_EN to honour LSL/LSR/ASR on register forms;
//        without it, register forms with a nonzero shift amount are invalid.
module fu_arith_pipe
    import fu_arith_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STAGES = 1,
    parameter int ID_W   = 6,
    parameter int PRN_W  = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        inst_valid,
    output logic                        fu_ready,
    input  logic [31:0]                 inst,
    input  logic [ID_W-1:0]             inst_id,
    input  logic [1:0][XLEN-1:0]        op,
    input  logic [2:0][PRN_W-1:0]       out_prn,
    input  logic [2:0]                  out_prn_valid,
    output logic                        fu_out_valid,
    input  logic                        fu_out_ready,
    output logic [ID_W-1:0]             fu_out_inst_id,
    output logic [2:0][PRN_W-1:0]       fu_out_prn,
    output logic [2:0]                  fu_out_prn_valid,
    output logic [2:0][XLEN-1:0]        fu_out_data,
    output logic [2:0]                  fu_out_data_valid
);

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [2:0][PRN_W-1:0] prn;
        logic [2:0]            prn_valid;
        logic [2:0][XLEN-1:0]  data;
        logic [2:0]            data_valid;
    } payload_t;

    localparam int PW = $bits(payload_t);

    // ------------------------------------------------------------------
    // Stage 0 compute
    // ------------------------------------------------------------------
    arith_op_e       aop;
    logic            is_imm;
    logic            is_sub;
    logic            set_flags;
    logic            enc_ok;
    logic [5:0]      shamt;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] s;
    logic [XLEN-1:0] flags;
    payload_t        p0;

    always_comb begin
        aop       = decode_op(inst[31:24]);
        is_imm    = inst[31:24] inside {OPC_ADD_IMM, OPC_ADDS_IMM, OPC_SUB_IMM, OPC_SUBS_IMM};
        is_sub    = (aop == SUB) || (aop == SUBS);
        set_flags = (aop == ADDS) || (aop == SUBS);
        enc_ok    = (aop != INVALID);
        shamt     = inst[15:10];
        a         = op[0];
        b         = op[1];

        if (is_imm) begin
            b = XLEN'(inst[21:10]);
            if (inst[22]) begin
                b = b << 12;
            end
        end else begin
            if (inst[21]) begin
                enc_ok = 1'b0;
            end
`ifdef FU_ARITH_SHIFT_EN
            case (inst[23:22])
                2'b00:   b = op[1] << shamt;
                2'b01:   b = op[1] >> shamt;
                2'b10:   b = $signed(op[1]) >>> shamt;
                default: enc_ok = 1'b0;
            endcase
`else
            if (shamt != 6'd0) begin
                enc_ok = 1'b0;
            end
`endif
        end

        // Subtract as a + ~b + 1 so the carry out is NOT borrow
        b_eff = is_sub ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};
        s     = sum[XLEN-1:0];

        flags         = '0;
        flags[FLAG_N] = s[XLEN-1];
        flags[FLAG_Z] = (s == '0);
        flags[FLAG_C] = sum[XLEN];
        flags[FLAG_V] = (a[XLEN-1] == b_eff[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);

        p0                = '0;
        p0.id             = inst_id;
        p0.prn            = out_prn;
        p0.prn_valid      = out_prn_valid;
        p0.data[0]        = s;
        p0.data[2]        = flags;
        // Rd=31 on a flag-setting op is CMP/CMN: only the flags are written
        p0.data_valid[0]  = enc_ok && !(set_flags && (inst[4:0] == 5'b11111));
        p0.data_valid[2]  = enc_ok && set_flags;
    end

    // Rn field is implied by op[0]; shift type high bit only matters with shifts enabled
`ifdef FU_ARITH_SHIFT_EN
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst[9:5];
`else
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst[23], inst[9:5]};
`endif

    // ------------------------------------------------------------------
    // Pipeline slots
    // ------------------------------------------------------------------
    logic [STAGES-1:0] stg_vld;
    logic [STAGES-1:0] stg_en;
    logic [PW-1:0]     stg_dat [STAGES];

    // A slot may load when it, or any slot downstream of it, has room,
    // or the output is being taken this cycle.
    always_comb begin
        stg_en = '0;
        for (int k = 0; k < STAGES; k++) begin
            stg_en[k] = fu_out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!stg_vld[j]) begin
                    stg_en[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          d_vld;
        logic [PW-1:0] d_dat;

        if (k == 0) begin : g_head
            assign d_vld = inst_valid;
            assign d_dat = p0;
        end else begin : g_tail
            assign d_vld = stg_vld[k-1];
            assign d_dat = stg_dat[k-1];
        end

        fu_arith_stage #(
            .W(PW)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .clr    (flush),
            .load_en(stg_en[k]),
            .d_vld  (d_vld),
            .d_dat  (d_dat),
            .q_vld  (stg_vld[k]),
            .q_dat  (stg_dat[k])
        );
    end

    // ------------------------------------------------------------------
    // Outputs from the last slot
    // ------------------------------------------------------------------
    payload_t po;
    assign po = stg_dat[STAGES-1];

    assign fu_ready          = stg_en[0];
    assign fu_out_valid      = stg_vld[STAGES-1];
    assign fu_out_inst_id    = po.id;
    assign fu_out_prn        = po.prn;
    assign fu_out_data       = po.data;
    // Payload is not reset, so qualifiers are masked while the slot is empty
    assign fu_out_prn_valid  = fu_out_valid ? po.prn_valid  : 3'b000;
    assign fu_out_data_valid = fu_out_valid ? po.data_valid : 3'b000;

endmodule

// File: tb/tb_fu_arith_pipe.sv
`timescale 1ns/1ps
module tb_fu_arith_pipe;

    localparam int XLEN   = 64;
    localparam int STAGES = 3;
    localparam int ID_W   = 6;
    localparam int PRN_W  = 7;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  inst_valid;
    logic                  fu_ready;
    logic [31:0]           inst;
    logic [ID_W-1:0]       inst_id;
    logic [1:0][XLEN-1:0]  op;
    logic [2:0][PRN_W-1:0] out_prn;
    logic [2:0]            out_prn_valid;
    logic                  fu_out_valid;
    logic                  fu_out_ready;
    logic [ID_W-1:0]       fu_out_inst_id;
    logic [2:0][PRN_W-1:0] fu_out_prn;
    logic [2:0]            fu_out_prn_valid;
    logic [2:0][XLEN-1:0]  fu_out_data;
    logic [2:0]            fu_out_data_valid;

    always #5 clk = ~clk;

    fu_arith_pipe #(
        .XLEN(XLEN), .STAGES(STAGES), .ID_W(ID_W), .PRN_W(PRN_W)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .inst_valid       (inst_valid),
        .fu_ready         (fu_ready),
        .inst             (inst),
        .inst_id          (inst_id),
        .op               (op),
        .out_prn          (out_prn),
        .out_prn_valid    (out_prn_valid),
        .fu_out_valid     (fu_out_valid),
        .fu_out_ready     (fu_out_ready),
        .fu_out_inst_id   (fu_out_inst_id),
        .fu_out_prn       (fu_out_prn),
        .fu_out_prn_valid (fu_out_prn_valid),
        .fu_out_data      (fu_out_data),
        .fu_out_data_valid(fu_out_data_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: architectural A64 add/sub semantics
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [2:0][PRN_W-1:0] prn;
        logic [2:0]            pv;
        logic [63:0]           r;
        logic [3:0]            nzcv;
        logic [2:0]            dv;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t model(input logic [31:0] i, input logic [63:0] a, input logic [63:0] m,
                                   input logic [ID_W-1:0] id, input logic [2:0][PRN_W-1:0] prn,
                                   input logic [2:0] pv);
        exp_t        e;
        bit          ok, sub, setf, imm, c, v;
        logic [63:0] b;
        int          sh;
        ok = 1; sub = 0; setf = 0; imm = 0; b = m;
        case (i[31:24])
            8'h91: imm = 1;
            8'hB1: begin imm = 1; setf = 1; end
            8'hD1: begin imm = 1; sub = 1; end
            8'hF1: begin imm = 1; sub = 1; setf = 1; end
            8'h8B: ;
            8'hAB: setf = 1;
            8'hCB: sub = 1;
            8'hEB: begin sub = 1; setf = 1; end
            default: ok = 0;
        endcase
        sh = int'(i[15:10]);
        if (imm) begin
            b = i[22] ? 64'(i[21:10]) * 4096 : 64'(i[21:10]);
        end else begin
            if (i[21]) ok = 0;
`ifdef FU_ARITH_SHIFT_EN
            case (i[23:22])
                2'd0:    b = m << sh;
                2'd1:    b = m >> sh;
                2'd2:    b = 64'($signed(m) >>> sh);
                default: ok = 0;
            endcase
`else
            if (sh != 0) ok = 0;
`endif
        end
        e.r    = sub ? a - b : a + b;
        c      = sub ? (a >= b) : (e.r < a);
        v      = sub ? (a[63] != b[63] && e.r[63] != a[63]) : (a[63] == b[63] && e.r[63] != a[63]);
        e.nzcv = {e.r[63], (e.r == 64'd0), c, v};
        e.dv   = ok ? {setf, 1'b0, !(setf && i[4:0] == 5'h1f)} : 3'b000;
        e.id   = id;
        e.prn  = prn;
        e.pv   = pv;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 9))
            0: i[31:24] = 8'h91;
            1: i[31:24] = 8'hB1;
            2: i[31:24] = 8'hD1;
            3: i[31:24] = 8'hF1;
            4: i[31:24] = 8'h8B;
            5: i[31:24] = 8'hAB;
            6: i[31:24] = 8'hCB;
            7: i[31:24] = 8'hEB;
            default: ;
        endcase
        if (i[27:24] == 4'hB) begin
            if ($urandom_range(0, 3) != 0) i[21] = 1'b0;
            if ($urandom_range(0, 1) == 0) i[15:10] = 6'd0;
        end
        if ($urandom_range(0, 3) == 0) i[4:0] = 5'h1f;
        return i;
    endfunction

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'($urandom_range(0, 8));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard (samples on the falling edge)
    // ------------------------------------------------------------------
    bit          mon_en     = 0;
    bit          stall_prev = 0;
    bit          saw_block  = 0;
    exp_t        mon_e;
    logic [63:0] snap_d0;
    logic [63:0] snap_meta;

    always @(negedge clk) begin
        if (mon_en) begin
            check("fu_ready", fu_ready, (fu_out_ready || sb.size() < STAGES));
            if (stall_prev) begin
                check("hold_vld", fu_out_valid, 1);
                check("hold_meta", {fu_out_inst_id, fu_out_prn, fu_out_prn_valid, fu_out_data_valid}, snap_meta);
                check("hold_d0", fu_out_data[0], snap_d0);
            end
            if (fu_out_valid) begin
                check("out_expected", (sb.size() != 0), 1);
                if (fu_out_ready && sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("meta", {fu_out_inst_id, fu_out_prn, fu_out_prn_valid}, {mon_e.id, mon_e.prn, mon_e.pv});
                    check("data_valid", fu_out_data_valid, mon_e.dv);
                    check("data1", fu_out_data[1], 64'd0);
                    if (mon_e.dv[0]) check("sum", fu_out_data[0], mon_e.r);
                    if (mon_e.dv[2]) check("flags", fu_out_data[2], {60'd0, mon_e.nzcv});
                end
            end
            if (inst_valid && fu_ready && !flush && !rst)
                sb.push_back(model(inst, op[0], op[1], inst_id, out_prn, out_prn_valid));
            if (inst_valid && !fu_ready) saw_block = 1;
            if (flush || rst) sb.delete();
            stall_prev = fu_out_valid && !fu_out_ready && !flush && !rst;
            snap_d0    = fu_out_data[0];
            snap_meta  = {fu_out_inst_id, fu_out_prn, fu_out_prn_valid, fu_out_data_valid};
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic set_op(input logic [31:0] i, input logic [63:0] a, input logic [63:0] m);
        inst          = i;
        op[0]         = a;
        op[1]         = m;
        inst_id       = ID_W'($urandom);
        out_prn       = (3*PRN_W)'({$urandom, $urandom});
        out_prn_valid = 3'($urandom);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic issue_single(input logic [31:0] i, input logic [63:0] a, input logic [63:0] m);
        @(posedge clk); #1;
        set_op(i, a, m);
        inst_valid = 1;
        @(posedge clk); #1;
        inst_valid = 0;
        wait_drain();
    endtask

    task automatic quiet_after(input string tag);
        int cnt;
        check({tag, "_ready"}, fu_ready, 1);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (fu_out_valid) cnt++;
        end
        check({tag, "_quiet"}, cnt, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1; flush = 0; inst_valid = 0; fu_out_ready = 1;
        set_op(32'd0, 64'd0, 64'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", fu_out_valid, 0);
        check("rst_data_valid", fu_out_data_valid, 0);
        check("rst_prn_valid", fu_out_prn_valid, 0);
        rst = 0;
        @(posedge clk); #1;
        check("rst_fu_ready", fu_ready, 1);
        mon_en = 1;

        // Latency on an empty pipe: ADD imm 5 + 3
        set_op(32'h9100_0C00 | 32'd2, 64'd5, 64'd0);
        inst_valid = 1;
        @(posedge clk); #1;
        inst_valid = 0;
        n = 0;
        for (int t = 0; t < 20; t++) begin
            n++;
            if (fu_out_valid) break;
            @(posedge clk); #1;
        end
        check("latency", n, STAGES);
        wait_drain();

        // CMP (SUBS reg, Rd=31), ADDS overflow, shifted ADD reg
        issue_single(32'hEB00_001F, 64'd5, 64'd5);
        issue_single(32'hAB00_0003, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        issue_single(32'h8B00_1005, 64'd1, 64'd2);
        issue_single(32'hD140_0407, 64'd0, 64'd0);

        // Five back-to-back issues with output stalled for three cycles
        saw_block = 0;
        n = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            fu_out_ready = !(c >= 4 && c <= 6);
            inst_valid   = (n < 5);
            if (n < 5) set_op(rand_inst(), rand_val(), rand_val());
            @(negedge clk);
            #1;
            if (inst_valid && fu_ready) n++;
        end
        @(posedge clk); #1;
        inst_valid = 0;
        fu_out_ready = 1;
        check("stall_all_issued", n, 5);
        check("stall_fu_ready_dropped", saw_block, 1);
        wait_drain();

        // Flush with two ops in flight plus a same-cycle issue
        @(posedge clk); #1;
        set_op(rand_inst(), rand_val(), rand_val()); inst_valid = 1;
        @(posedge clk); #1;
        set_op(rand_inst(), rand_val(), rand_val());
        @(posedge clk); #1;
        set_op(rand_inst(), rand_val(), rand_val()); flush = 1;
        @(posedge clk); #1;
        inst_valid = 0; flush = 0;
        quiet_after("flush");

        // Reset with ops in flight
        @(posedge clk); #1;
        set_op(rand_inst(), rand_val(), rand_val()); inst_valid = 1;
        @(posedge clk); #1;
        set_op(rand_inst(), rand_val(), rand_val());
        @(posedge clk); #1;
        inst_valid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        quiet_after("midrst");

        // Randomized traffic with backpressure and occasional flush
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            inst_valid   = ($urandom_range(0, 9) < 7);
            set_op(rand_inst(), rand_val(), rand_val());
            fu_out_ready = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk); #1;
        inst_valid = 0; flush = 0; fu_out_ready = 1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
